// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  // One folded key event as presented to the consumer
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 pin and debounces it with a stability counter.
// Latency: pin to filtered level in 2 + C_FILT_LEN cycles.
// Backpressure: none; free-running on every clock.
module ps2_line_filter #(
  parameter int C_FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filt
);

  localparam int CW = $clog2(C_FILT_LEN) + 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser, then adopt the new level only after C_FILT_LEN equal samples
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(C_FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Registers; idle PS/2 lines float high, so everything resets to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device->host frame receiver folding E0/F0 prefixes into single key events.
// Latency: event valid one cycle after the filtered stop-bit fall (pin + 3 + C_FILT_LEN cycles).
// Backpressure: one-entry holding register; an event completing while it is still held is dropped with err_overrun.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int C_FILT_LEN    = 4,
  parameter int C_TIMEOUT_CYC = 200000
) (
  input  logic       Bus2IP_Clk,
  input  logic       Bus2IP_Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       busy,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int DATA_BITS = PS2_FRAME_BITS - 3;
  localparam int WDW       = $clog2(C_TIMEOUT_CYC + 1);

  logic           clk_filt, data_filt, fall;
  logic           clk_prev_q, clk_prev_d;
  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           ext_pend_q, ext_pend_d;
  logic           brk_pend_q, brk_pend_d;
  key_evt_t       evt_q, evt_d;
  logic           evt_valid_q, evt_valid_d;
  logic           err_parity_q, err_parity_d;
  logic           err_frame_q, err_frame_d;
  logic           err_timeout_q, err_timeout_d;
  logic           err_overrun_q, err_overrun_d;

  logic           byte_good, byte_bad_par, byte_bad_stop, wd_expired;

  ps2_line_filter #(.C_FILT_LEN(C_FILT_LEN)) u_clk_filt (
    .clk  (Bus2IP_Clk),
    .rst  (Bus2IP_Reset),
    .pin  (ps2_clk),
    .filt (clk_filt)
  );

  ps2_line_filter #(.C_FILT_LEN(C_FILT_LEN)) u_data_filt (
    .clk  (Bus2IP_Clk),
    .rst  (Bus2IP_Reset),
    .pin  (ps2_data),
    .filt (data_filt)
  );

  // Fall strobe is high for the single cycle in which the filtered clock has just dropped
  assign fall = clk_prev_q & ~clk_filt;

  // Frame FSM, shift register and watchdog; classifies the byte at the stop-bit fall
  always_comb begin
    clk_prev_d    = clk_filt;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    wd_d          = wd_q;
    byte_good     = 1'b0;
    byte_bad_par  = 1'b0;
    byte_bad_stop = 1'b0;
    wd_expired    = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      wd_d = '0;
    end else if (wd_q == WDW'(C_TIMEOUT_CYC - 1)) begin
      wd_expired = 1'b1;
      wd_d       = '0;
    end else begin
      wd_d = wd_q + WDW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // A fall with data high is line noise, not a start bit
        if (fall && !data_filt) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_filt;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!data_filt)                          byte_bad_stop = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) byte_bad_par  = 1'b1;
          else                                     byte_good     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_expired) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end
  end

  // Prefix folding, event holding register and error pulses
  always_comb begin
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    evt_d         = evt_q;
    evt_valid_d   = evt_valid_q;
    err_parity_d  = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

    if (byte_bad_stop || byte_bad_par || wd_expired) begin
      // A broken frame may have been the key the prefixes belonged to
      ext_pend_d    = 1'b0;
      brk_pend_d    = 1'b0;
      err_frame_d   = byte_bad_stop;
      err_parity_d  = byte_bad_par;
      err_timeout_d = wd_expired;
    end else if (byte_good) begin
      if (shift_q == PS2_PFX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == PS2_PFX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (evt_valid_q && !evt_ready) begin
          err_overrun_d = 1'b1;
        end else begin
          evt_d.code  = shift_q;
          evt_d.ext   = ext_pend_q;
          evt_d.brk   = brk_pend_q;
          evt_valid_d = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      clk_prev_q    <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      wd_q          <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      evt_q         <= '0;
      evt_valid_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      clk_prev_q    <= clk_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      wd_q          <= wd_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      evt_q         <= evt_d;
      evt_valid_q   <= evt_valid_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_q.code;
  assign evt_ext     = evt_q.ext;
  assign evt_brk     = evt_q.brk;
  assign busy        = (state_q != ST_IDLE);
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule
